// File: rtl/phase_freq_pkg.sv
// Shared constants, helpers and state type for the phase-to-frequency estimator.
// PHASE_FREQ_ROUND_EN (see phase_freq_est) switches the output from floor to round-half-up.
package phase_freq_pkg;

    typedef enum logic {
        SEED = 1'b0,
        RUN  = 1'b1
    } state_t;

    // floor(pi * 2^32); the dropped fraction is far below one phase LSB for sane widths
    localparam logic [63:0] PI_2P32 = 64'd13493037704;

    function automatic int pi_q(input int width);
        logic [63:0] t;
        t = (PI_2P32 << (width - 3)) + 64'h0000_0000_8000_0000;
        return int'(t >> 32);
    endfunction

    function automatic int two_pi_q(input int width);
        return 2 * pi_q(width);
    endfunction

endpackage

// File: rtl/phase_freq_est_diff.sv
// Stage 1: holds the previous phase and registers the wrapped first difference.
// The difference is formed in WIDTH+1 bits so out-of-range phases still give defined results.
module phase_diff_wrap
    import phase_freq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [WIDTH-1:0]        phase_i,
    input  logic                    valid_i,
    input  logic                    seed_i,
    output logic signed [WIDTH-1:0] d_o,
    output logic                    d_valid_o
);
    localparam logic signed [WIDTH:0] PI_Q     = (WIDTH+1)'(pi_q(WIDTH));
    localparam logic signed [WIDTH:0] TWO_PI_Q = (WIDTH+1)'(two_pi_q(WIDTH));

    logic signed [WIDTH-1:0] prev_q, prev_d;
    logic signed [WIDTH-1:0] d_q, d_d;
    logic                    d_valid_q, d_valid_d;
    logic signed [WIDTH:0]   raw;
    logic signed [WIDTH:0]   wrapped;

    always_comb begin
        raw     = {phase_i[WIDTH-1], phase_i} - {prev_q[WIDTH-1], prev_q};
        wrapped = raw;
        // exactly +/-PI_Q is left alone
        if (raw > PI_Q) begin
            wrapped = raw - TWO_PI_Q;
        end else if (raw < -PI_Q) begin
            wrapped = raw + TWO_PI_Q;
        end

        prev_d    = prev_q;
        d_d       = d_q;
        d_valid_d = 1'b0;
        if (valid_i) begin
            prev_d = phase_i;
            if (!seed_i) begin
                d_d       = WIDTH'(wrapped);
                d_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q    <= '0;
            d_q       <= '0;
            d_valid_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            d_q       <= d_d;
            d_valid_q <= d_valid_d;
        end
    end

    assign d_o       = d_q;
    assign d_valid_o = d_valid_q;

endmodule

// File: rtl/phase_freq_est.sv
// Mean phase step over 2^LOG2_N wrapped differences = instantaneous frequency estimate.
// Define PHASE_FREQ_ROUND_EN to round half toward +inf instead of flooring.
module phase_freq_est
    import phase_freq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LOG2_N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sink,
    input  logic             sink_valid,
    output logic [WIDTH-1:0] source,
    output logic             source_valid,
    output state_t           dbg_state_o
);
`ifdef PHASE_FREQ_ROUND_EN
    localparam int AW = WIDTH + LOG2_N + 1;
`else
    localparam int AW = WIDTH + LOG2_N;
`endif
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    state_t                  state_q, state_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic [LOG2_N-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]        source_q, source_d;
    logic                    source_valid_q, source_valid_d;
    logic signed [WIDTH-1:0] d;
    logic                    d_valid;
    logic signed [AW-1:0]    sum;
    logic signed [AW-1:0]    rnd;
    logic [WIDTH-1:0]        mean;

    phase_diff_wrap #(.WIDTH(WIDTH)) u_diff (
        .clk_i     (clk),
        .rst_i     (reset),
        .phase_i   (sink),
        .valid_i   (sink_valid),
        .seed_i    (state_q == SEED),
        .d_o       (d),
        .d_valid_o (d_valid)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == SEED && sink_valid) begin
            state_d = RUN;
        end
    end

    always_comb begin
        sum = acc_q + {{(AW-WIDTH){d[WIDTH-1]}}, d};
`ifdef PHASE_FREQ_ROUND_EN
        rnd = sum + (AW'(1) << (LOG2_N - 1));
`else
        rnd = sum;
`endif
        mean = WIDTH'(rnd >>> LOG2_N);

        acc_d          = acc_q;
        cnt_d          = cnt_q;
        source_d       = source_q;
        source_valid_d = 1'b0;
        if (d_valid) begin
            if (cnt_q == CNT_LAST) begin
                source_d       = mean;
                source_valid_d = 1'b1;
                acc_d          = '0;
                cnt_d          = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= SEED;
            acc_q          <= '0;
            cnt_q          <= '0;
            source_q       <= '0;
            source_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            source_q       <= source_d;
            source_valid_q <= source_valid_d;
        end
    end

    assign source       = source_q;
    assign source_valid = source_valid_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_phase_freq_est.sv
// Bench for phase_freq_est: table of single-block vectors plus random streams vs. a reference model.
module tb_phase_freq_est;
  import phase_freq_pkg::*;

  localparam int WIDTH    = 16;
  localparam int LOG2_N   = 4;
  localparam int N        = 1 << LOG2_N;
  localparam int PI_Q     = 25736;
  localparam int TWO_PI_Q = 51472;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] sink = '0;
  logic             sink_valid = 1'b0;
  logic [WIDTH-1:0] source;
  logic             source_valid;
  state_t           dbg_state;

  phase_freq_est #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) dut (
    .clk          (clk),
    .reset        (reset),
    .sink         (sink),
    .sink_valid   (sink_valid),
    .source       (source),
    .source_valid (source_valid),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / checks ----------------
  int    n_checks = 0;
  int    n_pass   = 0;
  string cur_test = "reset";

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s/%s: got %0d, expected %0d (cycle %0d)", cur_test, name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] exp_q[$];
  int               exp_cyc_q[$];
  logic [WIDTH-1:0] last_src = '0;
  bit               m_seeded = 0;
  int               m_prev = 0;
  int               m_sum = 0;
  int               m_n = 0;
  bit               use_model = 1;
  int               tbl_exp = 0;

  function automatic int wrap_phase(input int p);
    if (p > PI_Q) return p - TWO_PI_Q;
    if (p < -PI_Q) return p + TWO_PI_Q;
    return p;
  endfunction

  function automatic int wrap_diff(input int raw);
    if (raw > PI_Q) return raw - TWO_PI_Q;
    if (raw < -PI_Q) return raw + TWO_PI_Q;
    return raw;
  endfunction

  function automatic int floor_div(input int s, input int n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  function automatic int mean_of(input int s);
`ifdef PHASE_FREQ_ROUND_EN
    return floor_div(s + N / 2, N);
`else
    return floor_div(s, N);
`endif
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_cyc_q.delete();
    m_seeded = 0;
    m_sum    = 0;
    m_n      = 0;
    last_src = '0;
  endtask

  task automatic model_step(input int ph, input bit v);
    int e;
    if (!v) return;
    if (!m_seeded) begin
      m_seeded = 1;
      m_prev   = ph;
      return;
    end
    m_sum += wrap_diff(ph - m_prev);
    m_prev = ph;
    m_n++;
    if (m_n == N) begin
      e = use_model ? mean_of(m_sum) : tbl_exp;
      exp_q.push_back(e[WIDTH-1:0]);
      exp_cyc_q.push_back(cyc + 2);
      m_sum = 0;
      m_n   = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int ph, input bit v);
    @(posedge clk);
    #1;
    sink       = ph[WIDTH-1:0];
    sink_valid = v;
    model_step(ph, v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset      = 1'b1;
    sink_valid = 1'b0;
    #1;
    model_clear();
    check("rst_source", int'($signed(source)), 0);
    check("rst_valid", int'(source_valid), 0);
    check("rst_state", int'(dbg_state), int'(SEED));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        n_checks++;
        $display("FAIL %s/missed_strobe: no strobe at cycle %0d, expected value %0d", cur_test,
                 exp_cyc_q[0], $signed(exp_q[0]));
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      if (source_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL %s/spurious_strobe: got source %0d at cycle %0d, expected no strobe",
                   cur_test, $signed(source), cyc);
        end else begin
          check("strobe_cycle", cyc, exp_cyc_q[0]);
          check("source", int'($signed(source)), int'($signed(exp_q[0])));
          last_src = exp_q[0];
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end else begin
        check("hold", int'($signed(source)), int'($signed(last_src)));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int start;
    int first_d;
    int rest_d;
    int exp_src;
  } vec_t;

  function automatic vec_t mk(input int start, input int first_d, input int rest_d,
                              input int e_floor, input int e_round);
    vec_t v;
    v.start   = start;
    v.first_d = first_d;
    v.rest_d  = rest_d;
`ifdef PHASE_FREQ_ROUND_EN
    v.exp_src = e_round;
`else
    v.exp_src = e_floor;
`endif
    return v;
  endfunction

  vec_t vecs[10];

  task automatic run_vec(input vec_t v);
    int ph;
    apply_reset();
    use_model = 0;
    tbl_exp   = v.exp_src;
    ph        = v.start;
    drive(ph, 1'b1);
    for (int i = 0; i < N; i++) begin
      ph = wrap_phase(ph + ((i == 0) ? v.first_d : v.rest_d));
      drive(ph, 1'b1);
    end
    idle(4);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ph;
    vecs[0] = mk(0, 100, 100, 100, 100);
    vecs[1] = mk(0, -300, -300, -300, -300);
    vecs[2] = mk(25000, 2000, 2000, 2000, 2000);
    vecs[3] = mk(-12868, 25736, 0, 1608, 1609);
    vecs[4] = mk(12868, -25736, 0, -1609, -1608);
    vecs[5] = mk(-12868, 25737, 0, -1609, -1608);
    vecs[6] = mk(0, 24, 0, 1, 2);
    vecs[7] = mk(0, -24, 0, -2, -1);
    vecs[8] = mk(0, 50, 50, 50, 50);
    vecs[9] = mk(1000, 7, 1, 1, 1);

    #1;
    check("init_source", int'($signed(source)), 0);
    check("init_valid", int'(source_valid), 0);
    check("init_state", int'(dbg_state), int'(SEED));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // continuous +100 ramp, four back-to-back blocks; seed takes exactly one sample
    cur_test  = "ramp100";
    apply_reset();
    use_model = 0;
    tbl_exp   = 100;
    ph        = 0;
    drive(ph, 1'b1);
    for (int i = 0; i < 4 * N; i++) begin
      ph = wrap_phase(ph + 100);
      drive(ph, 1'b1);
      if (i == 0) check("state_run", int'(dbg_state), int'(RUN));
    end
    idle(4);

    for (int k = 0; k < 10; k++) begin
      cur_test = $sformatf("vec%0d", k);
      run_vec(vecs[k]);
    end

    // +50 ramp with random valid gaps
    cur_test  = "gap_ramp50";
    apply_reset();
    use_model = 0;
    tbl_exp   = 50;
    ph        = 0;
    drive(ph, 1'b1);
    for (int i = 0; i < 4 * N; i++) begin
      while ($urandom_range(0, 1) == 0) drive(0, 1'b0);
      ph = wrap_phase(ph + 50);
      drive(ph, 1'b1);
    end
    idle(4);

    // random in-range phases with random gaps, checked by the model
    cur_test  = "random";
    apply_reset();
    use_model = 1;
    for (int i = 0; i < 400; i++) begin
      ph = int'($urandom_range(0, 2 * PI_Q)) - PI_Q;
      drive(ph, ($urandom_range(0, 3) != 0));
    end
    idle(4);

    // reset while the strobe is high
    cur_test  = "reset_on_strobe";
    apply_reset();
    use_model = 1;
    ph        = 0;
    drive(ph, 1'b1);
    for (int i = 0; i < N; i++) begin
      ph = wrap_phase(ph + 300);
      drive(ph, 1'b1);
    end
    drive(0, 1'b0);
    @(posedge clk);
    #1;
    check("strobe_pre", int'(source_valid), 1);
    check("source_pre", int'($signed(source)), 300);
    reset = 1'b1;
    #1;
    model_clear();
    check("strobe_async", int'(source_valid), 0);
    check("source_async", int'($signed(source)), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // reset after 9 samples of a block; the next block needs a full N diffs
    cur_test = "reset_mid_block";
    ph       = 0;
    drive(ph, 1'b1);
    for (int i = 0; i < 9; i++) begin
      ph = wrap_phase(ph + 5000);
      drive(ph, 1'b1);
    end
    apply_reset();
    ph = 1234;
    drive(ph, 1'b1);
    for (int i = 0; i < N; i++) begin
      ph = wrap_phase(ph + 77);
      drive(ph, 1'b1);
    end
    idle(5);

    cur_test = "drain";
    check("pending_strobes", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
